// File: rtl/ubc_pkg.sv
// ubc_pkg: cell/state codes, controller FSM states and line indexing for the ultimate board controller
package ubc_pkg;
  localparam logic [1:0] EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10, DRAW = 2'b11;
  typedef enum logic [1:0] {IDLE, CHK_MICRO, CHK_MACRO, DONE} fsm_t;
  // Lines 0..n-1 are rows, n..2n-1 columns, 2n the main diagonal, 2n+1 the anti-diagonal
  function automatic int line_idx(input int n, input int line, input int k);
    return line < n ? line * n + k : line < 2 * n ? k * n + line - n :
           line == 2 * n ? k * n + k : k * n + n - 1 - k;
  endfunction
endpackage

// File: rtl/ultimate_board_ctrl_if.sv
// ultimate_board_ctrl_if: move request, read and status signals between game FSM and board controller
interface ultimate_board_ctrl_if #(
  parameter int N_SIDE = 3,
  parameter int ADDR_W = 4,
  parameter int CELL_W = 2
);
  logic                              we;
  logic [CELL_W-1:0]                 data;
  logic [ADDR_W-1:0]                 addr_macro;
  logic [ADDR_W-1:0]                 addr_micro;
  logic [CELL_W-1:0]                 q;
  logic [CELL_W-1:0]                 state;
  logic [CELL_W-1:0]                 game_state;
  logic [N_SIDE*N_SIDE*CELL_W-1:0]   macro_states;
  logic                              ready;
  logic                              done;
  logic                              err;
  modport master (output we, data, addr_macro, addr_micro,
                  input q, state, game_state, macro_states, ready, done, err);
  modport slave  (input we, data, addr_macro, addr_micro,
                  output q, state, game_state, macro_states, ready, done, err);
endinterface

// File: rtl/ultimate_board_ctrl_line_check.sv
// line_check: returns the common player code of a line, 00 if cells differ, are empty or are draws
module line_check import ubc_pkg::*; #(
  parameter int N_SIDE = 3,
  parameter int CELL_W = 2
)(
  input  logic [CELL_W-1:0] i_cells [N_SIDE],
  output logic [CELL_W-1:0] o_win
);
  always_comb begin
    o_win = i_cells[0] == CELL_W'(DRAW) ? '0 : i_cells[0];
    for (int k = 1; k < N_SIDE; k++) o_win = i_cells[k] != i_cells[0] ? '0 : o_win;
  end
endmodule

// File: rtl/ultimate_board_ctrl.sv
// ultimate_board_ctrl: ultimate tic-tac-toe board store with validated moves and sequential line scans.
// Define UBC_DRAW_DETECT_EN to mark full micro boards and fully decided macro boards as draws.
module ultimate_board_ctrl import ubc_pkg::*; #(
  parameter int N_SIDE = 3,
  parameter int ADDR_W = 4,
  parameter int CELL_W = 2
)(
  input logic                  clock,
  input logic                  reset,
  ultimate_board_ctrl_if.slave bus
);
  localparam int NC = N_SIDE * N_SIDE;
  localparam int NL = 2 * N_SIDE + 2;
  localparam int LW = $clog2(NL);
  logic [CELL_W-1:0] r_cell [NC][NC];
  logic [CELL_W-1:0] r_macro [NC];
  logic [CELL_W-1:0] r_game, r_win, r_q, r_state;
  logic [ADDR_W-1:0] r_am;
  logic [LW-1:0]     r_line;
  logic              r_err;
  fsm_t              r_fsm, w_fsm_nx;
  logic [ADDR_W-1:0] w_idx [N_SIDE];
  logic [CELL_W-1:0] w_line [N_SIDE];
  logic [CELL_W-1:0] w_lw, w_found, w_micro_res, w_game_res;
  logic              w_in_rng, w_acc, w_rej, w_last, w_scan;
  assign w_in_rng = bus.addr_macro < ADDR_W'(NC) && bus.addr_micro < ADDR_W'(NC);
  assign w_acc = r_fsm == IDLE && bus.we && w_in_rng &&
                 (bus.data == CELL_W'(P1) || bus.data == CELL_W'(P2)) &&
                 r_cell[bus.addr_macro][bus.addr_micro] == CELL_W'(EMPTY) &&
                 r_macro[bus.addr_macro] == CELL_W'(EMPTY) && r_game == CELL_W'(EMPTY);
  assign w_rej = r_fsm == IDLE && bus.we && !w_acc;
  assign w_scan = r_fsm == CHK_MICRO || r_fsm == CHK_MACRO;
  assign w_last = r_line == LW'(NL - 1);
  // One line_check serves both phases; the FSM state selects cells or macro states
  always_comb begin
    for (int k = 0; k < N_SIDE; k++) begin
      w_idx[k] = ADDR_W'(line_idx(N_SIDE, int'(r_line), k));
      w_line[k] = r_fsm == CHK_MACRO ? r_macro[w_idx[k]] : r_cell[r_am][w_idx[k]];
    end
  end
  line_check #(.N_SIDE(N_SIDE), .CELL_W(CELL_W)) u_line (.i_cells(w_line), .o_win(w_lw));
  assign w_found = r_win != '0 ? r_win : w_lw;
`ifdef UBC_DRAW_DETECT_EN
  localparam int FW = $clog2(NC + 1);
  logic [FW-1:0] r_fill [NC];
  logic          w_all;
  always_ff @(posedge clock) begin
    for (int i = 0; i < NC; i++)
      if (reset) r_fill[i] <= '0;
      else if (w_acc && bus.addr_macro == ADDR_W'(i)) r_fill[i] <= r_fill[i] + 1'b1;
  end
  always_comb begin
    w_all = 1'b1;
    for (int i = 0; i < NC; i++) w_all = r_macro[i] == '0 ? 1'b0 : w_all;
  end
  assign w_micro_res = w_found != '0 ? w_found : r_fill[r_am] == FW'(NC) ? CELL_W'(DRAW) : CELL_W'(EMPTY);
  assign w_game_res  = w_found != '0 ? w_found : w_all ? CELL_W'(DRAW) : CELL_W'(EMPTY);
`else
  assign w_micro_res = w_found;
  assign w_game_res  = w_found;
`endif
  always_comb begin
    w_fsm_nx = r_fsm == IDLE ? (w_acc ? CHK_MICRO : IDLE) :
               r_fsm == DONE ? IDLE :
               !w_last ? r_fsm :
               r_fsm == CHK_MICRO ? CHK_MACRO : DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm   <= IDLE;
      r_game  <= '0;
      r_win   <= '0;
      r_q     <= '0;
      r_state <= '0;
      r_am    <= '0;
      r_line  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        r_macro[i] <= '0;
        for (int j = 0; j < NC; j++) r_cell[i][j] <= '0;
      end
    end else begin
      r_fsm   <= w_fsm_nx;
      r_err   <= w_rej;
      r_q     <= w_in_rng ? r_cell[bus.addr_macro][bus.addr_micro] : '0;
      r_state <= bus.addr_macro < ADDR_W'(NC) ? r_macro[bus.addr_macro] : '0;
      r_line  <= w_scan && !w_last ? r_line + 1'b1 : '0;
      r_win   <= w_scan && !w_last ? w_found : '0;
      if (w_acc) begin
        r_cell[bus.addr_macro][bus.addr_micro] <= bus.data;
        r_am <= bus.addr_macro;
      end
      if (r_fsm == CHK_MICRO && w_last) r_macro[r_am] <= w_micro_res;
      if (r_fsm == CHK_MACRO && w_last) r_game <= w_game_res;
    end
  end
  assign bus.q          = r_q;
  assign bus.state      = r_state;
  assign bus.game_state = r_game;
  assign bus.ready      = r_fsm == IDLE;
  assign bus.done       = r_fsm == DONE;
  assign bus.err        = r_err;
  always_comb begin
    bus.macro_states = '0;
    for (int i = 0; i < NC; i++) bus.macro_states[i*CELL_W +: CELL_W] = r_macro[i];
  end
endmodule
